i2c_master_bit_engine: RTL and testbench

I2C_MASTER_BIT_ENGINE -- requirements
Module: i2c_master_bit_engine

---
 rtl/i2c_master_bit_engine.sv | 193 +++++++++++++++++++
 tb/tb_i2c_master_bit_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_bit_engine.sv
// I2C master bit engine: sequences START, byte WRITE, byte READ and STOP on an
// open-drain bus in quarter-period steps, with clock stretching and bus-ownership checks.
module i2c_master_bit_engine #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       tx_nack,
    output logic       cmd_ready,
    output logic       done,
    output logic       cmd_err,
    output logic [7:0] rx_data,
    output logic       rx_nack,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REJECT, ST_FINISH} state_t;

    state_t           state_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       q_r;
    logic [3:0]       bit_r;
    logic [1:0]       cmd_r;
    logic [7:0]       tx_sr_r;
    logic             nack_r;
    logic             err_r;
    logic             bus_owned_r;

    logic             hold_s;
    logic             tick_s;
    logic             last_s;
    logic             cur_oe_s;
    logic             next_oe_s;

    // SDA pull-down for one data bit; index 8 is the acknowledge slot
    function automatic logic bit_oe(input logic [1:0] c, input logic [3:0] bit_idx,
                                    input logic tx_bit, input logic nack);
        logic oe;
        case (c)
            CMD_WRITE: oe = (bit_idx == 4'd8) ? 1'b0 : ~tx_bit;
            CMD_READ:  oe = (bit_idx == 4'd8) ? ~nack : 1'b0;
            default:   oe = 1'b0;
        endcase
        return oe;
    endfunction

    // {scl_oe, sda_oe} to present while in quarter q of command c
    function automatic logic [1:0] quarter_drive(input logic [1:0] c, input logic [1:0] q,
                                                 input logic data_oe, input logic cur_scl);
        logic [1:0] drv;
        case (c)
            CMD_START: begin
                case (q)
                    2'd0:    drv = {cur_scl, 1'b0};
                    2'd1:    drv = 2'b00;
                    2'd2:    drv = 2'b01;
                    default: drv = 2'b11;
                endcase
            end
            CMD_STOP: begin
                case (q)
                    2'd0:    drv = 2'b11;
                    2'd1:    drv = 2'b01;
                    default: drv = 2'b00;
                endcase
            end
            default: drv = {(q == 2'd0) || (q == 2'd3), data_oe};
        endcase
        return drv;
    endfunction

    // Divider hold (stretching / waiting for a free bus) and quarter tick
    always_comb begin
        hold_s = 1'b0;
        tick_s = 1'b0;
        if (state_r == ST_RUN) begin
            hold_s = ((q_r == 2'd1) && !scl_in) ||
                     ((q_r == 2'd0) && (cmd_r == CMD_START) && !bus_owned_r && !(scl_in && sda_in));
            tick_s = !hold_s && (div_r == DIV_LAST);
        end else begin
            hold_s = 1'b0;
            tick_s = 1'b0;
        end
    end

    assign last_s    = (cmd_r == CMD_START) || (cmd_r == CMD_STOP) || (bit_r == 4'd8);
    assign cur_oe_s  = bit_oe(cmd_r, bit_r, tx_sr_r[7], nack_r);
    assign next_oe_s = bit_oe(cmd_r, bit_r + 4'd1, tx_sr_r[6], nack_r);

    // Command acceptance, quarter sequencing, bus drive and sampling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            div_r       <= '0;
            q_r         <= 2'd0;
            bit_r       <= 4'd0;
            cmd_r       <= CMD_START;
            tx_sr_r     <= 8'h00;
            nack_r      <= 1'b0;
            err_r       <= 1'b0;
            bus_owned_r <= 1'b0;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
            rx_data     <= 8'h00;
            rx_nack     <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    div_r <= '0;
                    if (cmd_valid && cmd_ready) begin
                        cmd_r     <= cmd;
                        tx_sr_r   <= tx_data;
                        nack_r    <= tx_nack;
                        q_r       <= 2'd0;
                        bit_r     <= 4'd0;
                        cmd_ready <= 1'b0;
                        if ((cmd != CMD_START) && !bus_owned_r) begin
                            err_r   <= 1'b1;
                            state_r <= ST_REJECT;
                        end else begin
                            err_r   <= 1'b0;
                            state_r <= ST_RUN;
                            {scl_oe, sda_oe} <= quarter_drive(cmd, 2'd0,
                                bit_oe(cmd, 4'd0, tx_data[7], tx_nack), scl_oe);
                        end
                    end
                end
                ST_RUN: begin
                    if (hold_s || tick_s) begin
                        div_r <= '0;
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                    if (tick_s) begin
                        if (q_r == 2'd2) begin
                            if ((cmd_r == CMD_READ) && (bit_r != 4'd8)) begin
                                rx_data <= {rx_data[6:0], sda_in};
                            end else if ((cmd_r == CMD_WRITE) && (bit_r == 4'd8)) begin
                                rx_nack <= sda_in;
                            end
                        end
                        if (q_r != 2'd3) begin
                            q_r <= q_r + 2'd1;
                            {scl_oe, sda_oe} <= quarter_drive(cmd_r, q_r + 2'd1, cur_oe_s, scl_oe);
                        end else if (last_s) begin
                            state_r <= ST_FINISH;
                        end else begin
                            q_r     <= 2'd0;
                            bit_r   <= bit_r + 4'd1;
                            tx_sr_r <= {tx_sr_r[6:0], 1'b0};
                            {scl_oe, sda_oe} <= quarter_drive(cmd_r, 2'd0, next_oe_s, scl_oe);
                        end
                    end
                end
                ST_REJECT: begin
                    state_r <= ST_FINISH;
                end
                ST_FINISH: begin
                    done      <= 1'b1;
                    cmd_err   <= err_r;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                    if (!err_r && (cmd_r == CMD_START)) begin
                        bus_owned_r <= 1'b1;
                    end else if (!err_r && (cmd_r == CMD_STOP)) begin
                        bus_owned_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// Directed bench for i2c_master_bit_engine at CLK_DIV=4 with a simple open-drain
// bus and byte-level slave model; expected values are hand-computed.
module tb_i2c_master_bit_engine;
    localparam int CLK_DIV = 4;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       tx_nack;
    logic       cmd_ready, done, cmd_err, rx_nack, scl_oe, sda_oe;
    logic [7:0] rx_data;
    logic       scl_line, sda_line;

    logic       stretch, slave_en, slave_low;
    logic [8:0] slave_pat;
    logic [8:0] cap;
    int         slave_idx = 0;
    int         slave_base;

    int   checks = 0;
    int   failures = 0;
    int   lat, dcount;
    logic got_err, got_ready, busy_seen, touched, seen_a, seen_b, prev_sda, poke;

    i2c_master_bit_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .tx_data(tx_data),
        .tx_nack(tx_nack), .cmd_ready(cmd_ready), .done(done), .cmd_err(cmd_err),
        .rx_data(rx_data), .rx_nack(rx_nack), .scl_in(scl_line), .sda_in(sda_line),
        .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    assign scl_line = ~scl_oe & ~stretch;
    assign sda_line = ~sda_oe & ~slave_low;

    // Slave advances to its next bit on each SCL fall
    always @(negedge scl_line) slave_idx <= slave_idx + 1;

    // Last nine SDA values seen on SCL rising edges
    always @(posedge scl_line) cap <= {cap[7:0], sda_line};

    always_comb begin
        slave_low = 1'b0;
        if (slave_en && (slave_idx - slave_base) >= 0 && (slave_idx - slave_base) < 9)
            slave_low = ~slave_pat[8 - (slave_idx - slave_base)];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic n, input int limit);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c; tx_data = d; tx_nack = n;
        slave_base = slave_idx;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        busy_seen = ~cmd_ready;
        touched = scl_oe | sda_oe;
        seen_a = 1'b0; seen_b = 1'b0; prev_sda = sda_line;
        lat = 0; got_err = 1'b0; got_ready = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            if (poke && k == 5) begin
                cmd_valid = 1'b1; cmd = C_STOP;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            touched = touched | scl_oe | sda_oe;
            if (!scl_line && sda_line) seen_a = 1'b1;
            if (seen_a && prev_sda && !sda_line && scl_line) seen_b = 1'b1;
            prev_sda = sda_line;
            if (done) begin
                lat = k; got_err = cmd_err; got_ready = cmd_ready;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    task automatic stretch_bit3();
        for (int k = 0; k < 400 && (slave_idx - slave_base) < 3; k++) @(negedge clk);
        stretch = 1'b1;
        for (int k = 0; k < 100 && scl_oe; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        stretch = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd = 2'b00; tx_data = 8'h00; tx_nack = 1'b0;
        stretch = 1'b0; slave_en = 1'b0; slave_pat = 9'h1FF; slave_base = 0; poke = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", cmd_err, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_nack", rx_nack, 1'b0);
        @(negedge clk) reset = 1'b0;

        // WRITE without owning the bus
        run_cmd(C_WRITE, 8'h55, 1'b0, 20);
        check("rej_lat", lat, 2);
        check("rej_err", got_err, 1'b1);
        check("rej_lines", touched, 1'b0);
        check("rej_busy", busy_seen, 1'b1);

        // START, WRITE A0 with ACK, STOP
        run_cmd(C_START, 8'h00, 1'b0, 60);
        check("start_lat", lat, 17);
        check("start_err", got_err, 1'b0);
        check("start_hold", {scl_oe, sda_oe}, 2'b11);
        slave_pat = 9'b1_1111_1110; slave_en = 1'b1;
        run_cmd(C_WRITE, 8'hA0, 1'b0, 220);
        check("wr_lat", lat, 145);
        check("wr_ready_at_done", got_ready, 1'b1);
        check("wr_err", got_err, 1'b0);
        check("wr_bits", cap[8:1], 8'hA0);
        check("wr_ack_bit", cap[0], 1'b0);
        check("wr_rx_nack", rx_nack, 1'b0);
        check("wr_scl_held", scl_oe, 1'b1);
        slave_en = 1'b0;
        run_cmd(C_STOP, 8'h00, 1'b0, 60);
        check("stop_lat", lat, 17);
        check("stop_oe", {scl_oe, sda_oe}, 2'b00);
        check("stop_lines", {scl_line, sda_line}, 2'b11);

        // START, READ 5A with NACK
        run_cmd(C_START, 8'h00, 1'b0, 60);
        check("start2_lat", lat, 17);
        slave_pat = {8'h5A, 1'b1}; slave_en = 1'b1;
        run_cmd(C_READ, 8'h00, 1'b1, 220);
        check("rd_lat", lat, 145);
        check("rd_data", rx_data, 8'h5A);
        check("rd_nack_bit", cap[0], 1'b1);
        check("rd_err", got_err, 1'b0);
        check("rd_rx_nack_held", rx_nack, 1'b0);

        // WRITE 3C, slave NACKs and stretches SCL 20 cycles in bit 3
        slave_pat = 9'h1FF;
        slave_base = slave_idx;
        fork
            run_cmd(C_WRITE, 8'h3C, 1'b0, 260);
            stretch_bit3();
        join
        check("str_lat", lat, 165);
        check("str_bits", cap[8:1], 8'h3C);
        check("str_rx_nack", rx_nack, 1'b1);
        check("str_rx_data_held", rx_data, 8'h5A);

        // Repeated START with an ignored command poked while busy
        slave_en = 1'b0; poke = 1'b1;
        run_cmd(C_START, 8'h00, 1'b0, 60);
        poke = 1'b0;
        check("rs_lat", lat, 17);
        check("rs_sda_high_scl_low", seen_a, 1'b1);
        check("rs_sda_fall_scl_high", seen_b, 1'b1);
        count_done(30, dcount);
        check("ignored_cmd_dones", dcount, 0);
        check("rs_bus_held", scl_oe, 1'b1);
        run_cmd(C_STOP, 8'h00, 1'b0, 60);
        check("stop2_lat", lat, 17);

        // Reset during bit 5 of a READ
        run_cmd(C_START, 8'h00, 1'b0, 60);
        check("start3_lat", lat, 17);
        slave_pat = {8'h5A, 1'b1}; slave_en = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd = C_READ; tx_nack = 1'b0;
        slave_base = slave_idx;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 400 && (slave_idx - slave_base) < 5; k++) @(negedge clk);
        repeat (6) @(negedge clk);
        check("pre_rst_scl", scl_oe, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_scl_oe", scl_oe, 1'b0);
        check("arst_sda_oe", sda_oe, 1'b0);
        check("arst_ready", cmd_ready, 1'b1);
        check("arst_rx_data", rx_data, 8'h00);
        slave_en = 1'b0;
        count_done(3, dcount);
        @(negedge clk) reset = 1'b0;
        count_done(40, lat);
        check("abort_no_done", dcount + lat, 0);
        run_cmd(C_START, 8'h00, 1'b0, 60);
        check("post_rst_start_lat", lat, 17);
        check("post_rst_start_err", got_err, 1'b0);
        run_cmd(C_STOP, 8'h00, 1'b0, 60);
        check("post_rst_stop_lat", lat, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
